// File: rtl/mips_cpu_avl_pkg.sv
// Shared types and constants for the CPU-side Avalon-MM master bridge.
package mips_cpu_avl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef enum logic {
    OWN_INSTR,
    OWN_DATA
  } owner_t;

  // Read data returned to the owner when a transfer is abandoned on timeout.
  localparam logic [31:0] AVL_TIMEOUT_DATA = 32'hDEADBEEF;

  // The Avalon side is word addressed; byte offsets are carried by byteenable.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_cpu_avl_arbiter.sv
// Fixed-priority select between the fetch port and the load/store port.
module mips_cpu_avl_arbiter
  import mips_cpu_avl_pkg::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic   instr_req_i,
  input  logic   data_req_i,
  output logic   any_req_o,
  output owner_t owner_o
);

  // Pure combinational pick; the top only samples it while idle.
  always_comb begin
    any_req_o = instr_req_i | data_req_i;
    owner_o   = OWN_INSTR;
    if (instr_req_i && data_req_i)
      owner_o = (DATA_PRIORITY != 0) ? OWN_DATA : OWN_INSTR;
    else if (data_req_i)
      owner_o = OWN_DATA;
  end

endmodule

// File: rtl/mips_cpu_avl_master_bridge.sv
// Merges the CPU fetch and load/store ports onto one Avalon-MM master.
// Optional stall timeout with sticky bus_err: define MIPS_CPU_AVL_TIMEOUT_EN.
module mips_cpu_avl_master_bridge
  import mips_cpu_avl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DATA_PRIORITY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_rdata,
  output logic        instr_done,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  output logic [31:0] avm_address,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  output logic        avm_read,
  output logic        avm_write,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy
`ifdef MIPS_CPU_AVL_TIMEOUT_EN
  ,
  output logic        bus_err
`endif
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q;
  owner_t      owner_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        read_q;
  logic        write_q;
  logic [31:0] instr_rdata_q;
  logic [31:0] data_rdata_q;
  logic        instr_done_q;
  logic        data_done_q;

  logic        any_req;
  owner_t      sel_owner;

  // Byte offsets never reach the bus; lanes come from data_be alone.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{instr_addr[1:0], data_addr[1:0]};

  mips_cpu_avl_arbiter #(
    .DATA_PRIORITY(DATA_PRIORITY)
  ) u_arb (
    .instr_req_i(instr_req),
    .data_req_i (data_req),
    .any_req_o  (any_req),
    .owner_o    (sel_owner)
  );

`ifdef MIPS_CPU_AVL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_q;
  logic          bus_err_q;
  logic          tmo_hit;
  // This stall cycle would be the TIMEOUT_CYCLES-th consecutive one.
  assign tmo_hit = avm_waitrequest && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign bus_err = bus_err_q;
`endif

  // Transfer FSM: all bus strobes, rdata and done pulses are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= OWN_INSTR;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
      instr_done_q  <= 1'b0;
      data_done_q   <= 1'b0;
`ifdef MIPS_CPU_AVL_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      bus_err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          instr_done_q <= 1'b0;
          data_done_q  <= 1'b0;
`ifdef MIPS_CPU_AVL_TIMEOUT_EN
          tmo_cnt_q    <= '0;
`endif
          if (any_req) begin
            owner_q <= sel_owner;
            state_q <= ISSUE;
            if (sel_owner == OWN_DATA) begin
              addr_q  <= word_align(data_addr);
              be_q    <= data_be;
              wdata_q <= data_wdata;
              write_q <= data_we;
              read_q  <= ~data_we;
            end else begin
              addr_q  <= word_align(instr_addr);
              be_q    <= 4'hF;
              write_q <= 1'b0;
              read_q  <= 1'b1;
            end
          end
        end

        ISSUE: begin
          if (!avm_waitrequest) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            state_q <= RESP;
            if (owner_q == OWN_DATA) begin
              data_done_q <= 1'b1;
              if (read_q) data_rdata_q <= avm_readdata;
            end else begin
              instr_done_q <= 1'b1;
              if (read_q) instr_rdata_q <= avm_readdata;
            end
          end
`ifdef MIPS_CPU_AVL_TIMEOUT_EN
          else if (tmo_hit) begin
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            state_q   <= RESP;
            bus_err_q <= 1'b1;
            if (owner_q == OWN_DATA) begin
              data_done_q  <= 1'b1;
              data_rdata_q <= AVL_TIMEOUT_DATA;
            end else begin
              instr_done_q  <= 1'b1;
              instr_rdata_q <= AVL_TIMEOUT_DATA;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end

        RESP: begin
          instr_done_q <= 1'b0;
          data_done_q  <= 1'b0;
          state_q      <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign avm_address    = addr_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = wdata_q;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign instr_rdata    = instr_rdata_q;
  assign data_rdata     = data_rdata_q;
  assign instr_done     = instr_done_q;
  assign data_done      = data_done_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mips_cpu_avl_master_bridge.sv
// Self-checking bench for mips_cpu_avl_master_bridge with a stalling memory slave.
// Define MIPS_CPU_AVL_TIMEOUT_EN to also exercise the timeout path.
module tb_mips_cpu_avl_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;
  logic        instr_done;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
`ifdef MIPS_CPU_AVL_TIMEOUT_EN
  logic        bus_err;
`endif

  always #5 clk = ~clk;

  mips_cpu_avl_master_bridge #(
    .TIMEOUT_CYCLES(8),
    .DATA_PRIORITY (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_req      (instr_req),
    .instr_addr     (instr_addr),
    .instr_rdata    (instr_rdata),
    .instr_done     (instr_done),
    .data_req       (data_req),
    .data_we        (data_we),
    .data_addr      (data_addr),
    .data_be        (data_be),
    .data_wdata     (data_wdata),
    .data_rdata     (data_rdata),
    .data_done      (data_done),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_writedata  (avm_writedata),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy)
`ifdef MIPS_CPU_AVL_TIMEOUT_EN
    ,
    .bus_err        (bus_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- memory slave: stall_n waitrequest cycles per transfer
  logic [31:0] mem [256];
  int          stall_n = 0;
  int          wcnt;
  logic        strobe;
  logic [31:0] be_mask;
  assign strobe          = avm_read | avm_write;
  assign avm_waitrequest = strobe && (wcnt < stall_n);
  assign be_mask         = {{8{avm_byteenable[3]}}, {8{avm_byteenable[2]}},
                            {8{avm_byteenable[1]}}, {8{avm_byteenable[0]}}};
  assign avm_readdata    = avm_read ? (mem[avm_address[9:2]] & be_mask) : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (strobe && avm_waitrequest) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
      if (avm_write)
        for (int b = 0; b < 4; b++)
          if (avm_byteenable[b]) mem[avm_address[9:2]][8*b +: 8] <= avm_writedata[8*b +: 8];
    end
  end

  // ---------------- scoreboard: expected rdata per port, popped on done
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  always @(negedge clk) begin
    if (instr_done) begin
      if (iq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected instr_done: got 1 expected 0");
      end else chk("instr_rdata", instr_rdata, iq.pop_front());
    end
    if (data_done) begin
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected data_done: got 1 expected 0");
      end else chk("data_rdata", data_rdata, dq.pop_front());
    end
    if (strobe) chk("rd_wr_overlap", {31'b0, avm_read & avm_write}, 32'h0);
  end

  // ---------------- vector table
  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          stalls;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    int held;
    logic same;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    logic        r0, wr0;
    @(negedge clk);
    stall_n = v.stalls;
    if (v.is_data) begin
      data_req = 1'b1; data_we = v.we; data_addr = v.addr; data_be = v.be; data_wdata = v.wdata;
      dq.push_back(v.exp_rdata);
    end else begin
      instr_req = 1'b1; instr_addr = v.addr;
      iq.push_back(v.exp_rdata);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!strobe && n < 20);
    chk({nm, " avm_address"}, avm_address, v.exp_addr);
    chk({nm, " avm_byteenable"}, {28'b0, avm_byteenable}, {28'b0, v.is_data ? v.be : 4'hF});
    chk({nm, " avm_write"}, {31'b0, avm_write}, {31'b0, v.is_data && v.we});
    chk({nm, " avm_read"}, {31'b0, avm_read}, {31'b0, !(v.is_data && v.we)});
    if (v.is_data && v.we) chk({nm, " avm_writedata"}, avm_writedata, v.wdata);
    a0 = avm_address; b0 = avm_byteenable; w0 = avm_writedata; r0 = avm_read; wr0 = avm_write;
    held = 0;
    while (avm_waitrequest && held < 100) begin
      @(negedge clk); held++;
      same = (avm_address === a0) && (avm_byteenable === b0) && (avm_writedata === w0) &&
             (avm_read === r0) && (avm_write === wr0);
      chk({nm, " hold"}, {31'b0, same}, 32'h1);
    end
    chk({nm, " stall_cycles"}, held, v.stalls);
    n = 0;
    while (!(v.is_data ? data_done : instr_done) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL %s done_timeout: got no done expected done", nm);
      if (v.is_data) void'(dq.pop_back()); else void'(iq.pop_back());
    end else begin
      chk({nm, " strobes_in_resp"}, {31'b0, strobe}, 32'h0);
      chk({nm, " busy_in_resp"}, {31'b0, busy}, 32'h1);
    end
    if (v.is_data) data_req = 1'b0; else instr_req = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    int n, t_i, t_d;
    rst = 1'b1;
    instr_req = 0; instr_addr = 0; data_req = 0; data_we = 0; data_addr = 0; data_be = 0; data_wdata = 0;

    //                 data we  addr          be     wdata         st exp_addr      exp_rdata
    vecs[0] = '{1'b1, 1'b1, 32'hBFC00004, 4'hF, 32'h2402000A, 0, 32'hBFC00004, 32'h00000000};
    vecs[1] = '{1'b0, 1'b0, 32'hBFC00004, 4'h0, 32'h0,        1, 32'hBFC00004, 32'h2402000A};
    vecs[2] = '{1'b1, 1'b1, 32'h00000010, 4'h3, 32'hAABBCCDD, 0, 32'h00000010, 32'h00000000};
    vecs[3] = '{1'b1, 1'b0, 32'h00000010, 4'hF, 32'h0,        1, 32'h00000010, 32'h0000CCDD};
    vecs[4] = '{1'b1, 1'b1, 32'h00000013, 4'hC, 32'h11223344, 2, 32'h00000010, 32'h0000CCDD};
    vecs[5] = '{1'b1, 1'b0, 32'h00000012, 4'hC, 32'h0,        0, 32'h00000010, 32'h11220000};
    vecs[6] = '{1'b1, 1'b1, 32'h00400000, 4'hF, 32'h8FBF0010, 0, 32'h00400000, 32'h11220000};
    vecs[7] = '{1'b0, 1'b0, 32'h00400002, 4'h0, 32'h0,        5, 32'h00400000, 32'h8FBF0010};
    vecs[8] = '{1'b1, 1'b0, 32'h00000010, 4'hF, 32'h0,        3, 32'h00000010, 32'h1122CCDD};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst avm_address", avm_address, 32'h0);
    chk("rst avm_byteenable", {28'b0, avm_byteenable}, 32'h0);
    chk("rst avm_writedata", avm_writedata, 32'h0);
    chk("rst strobes", {30'b0, avm_read, avm_write}, 32'h0);
    chk("rst instr_rdata", instr_rdata, 32'h0);
    chk("rst data_rdata", data_rdata, 32'h0);
    chk("rst dones", {30'b0, instr_done, data_done}, 32'h0);
    chk("rst busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous fetch and load: data wins, fetch follows after RESP+IDLE
    @(negedge clk);
    stall_n = 1;
    instr_req = 1'b1; instr_addr = 32'hBFC00004; iq.push_back(32'h2402000A);
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h10; data_be = 4'hF; dq.push_back(32'h1122CCDD);
    t_i = -1; t_d = -1; n = 0;
    while ((t_i < 0 || t_d < 0) && n < 100) begin
      @(negedge clk); n++;
      if (data_done)  begin t_d = n; data_req = 1'b0; end
      if (instr_done) begin t_i = n; instr_req = 1'b0; end
    end
    chk("simul both_done", {30'b0, t_i >= 0, t_d >= 0}, 32'h3);
    chk("simul data_first", {31'b0, t_d < t_i}, 32'h1);
    chk("simul gap", t_i - t_d, 4);
    instr_req = 1'b0; data_req = 1'b0;

    // Async reset in the middle of a stalled fetch
    @(negedge clk);
    stall_n = 50;
    instr_req = 1'b1; instr_addr = 32'h00000040;
    n = 0;
    do begin @(negedge clk); n++; end while (!avm_read && n < 20);
    chk("rstmid read_issued", {31'b0, avm_read}, 32'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstmid avm_read", {31'b0, avm_read}, 32'h0);
    chk("rstmid busy", {31'b0, busy}, 32'h0);
    chk("rstmid instr_rdata", instr_rdata, 32'h0);
    @(negedge clk);
    instr_req = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_vec('{1'b1, 1'b1, 32'h00000040, 4'hF, 32'h12345678, 0, 32'h00000040, 32'h0}, "post_rst_store");
    run_vec('{1'b0, 1'b0, 32'h00000040, 4'h0, 32'h0,        1, 32'h00000040, 32'h12345678}, "post_rst_fetch");

`ifdef MIPS_CPU_AVL_TIMEOUT_EN
    // Waitrequest stuck high: abort after 8 stall cycles
    @(negedge clk);
    chk("tmo bus_err_before", {31'b0, bus_err}, 32'h0);
    stall_n = 1000;
    instr_req = 1'b1; instr_addr = 32'h80; iq.push_back(32'hDEADBEEF);
    n = 0;
    do begin @(negedge clk); n++; end while (!avm_read && n < 20);
    t_i = 0;
    while (avm_read && t_i < 50) begin @(negedge clk); t_i++; end
    chk("tmo strobe_cycles", t_i, 8);
    chk("tmo done", {31'b0, instr_done}, 32'h1);
    chk("tmo bus_err", {31'b0, bus_err}, 32'h1);
    instr_req = 1'b0;
    stall_n = 0;
    repeat (4) @(negedge clk);
    chk("tmo bus_err_sticky", {31'b0, bus_err}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("tmo bus_err_rst", {31'b0, bus_err}, 32'h0);
    rst = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("iq drained", iq.size(), 0);
    chk("dq drained", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
